// File: rtl/imem_stream_loader.sv
// imem_stream_loader
//   Turns a little-endian byte stream into 32-bit IMEM word writes and holds
//   the core in reset until the image is fully loaded.
//   Stream: CNT_LO, CNT_HI (word count N), then N words of 4 bytes, LSB first.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   load_start        single-cycle pulse starting a load session
//   in_valid/in_data  byte source; transfer when in_valid && in_ready
//   in_ready          loader can take a byte this cycle
//   imem_we           one-cycle write strobe per assembled word
//   imem_addr/wdata   word-aligned byte address and word; hold between writes
//   core_rst          datapath reset, low only once loading is DONE
//   done / err        load complete / word count exceeded DEPTH
//   words_loaded      words written in the current session
module imem_stream_loader #(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_CHECK, S_DATA, S_WRITE, S_DONE, S_ERROR
    } state_e;

    // 17 bits so a 16-bit count can be compared against DEPTH without truncation
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [31:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       words_q, words_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        words_d    = words_q;
        in_ready   = 1'b0;
        imem_we    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (load_start) begin
                    state_d = S_LEN0;
                    words_d = '0;
                end
            end
            S_LEN0: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_d[7:0] = in_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_d[15:8] = in_data;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else if ({1'b0, cnt_q} > DEPTH_W) begin
                    state_d = S_ERROR;
                end else begin
                    state_d    = S_DATA;
                    byte_idx_d = '0;
                    word_idx_d = '0;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    asm_d[{byte_idx_q, 3'b000} +: 8] = in_data;
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Last byte: latch the output registers now so the write
                    // is presented in the very next cycle.
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                        addr_d  = BASE_ADDR + (ADDR_W'(word_idx_q) << 2);
                        wdata_d = {in_data, asm_q[23:0]};
                    end
                end
            end
            S_WRITE: begin
                imem_we = 1'b1;
                words_d = words_q + 16'd1;
                if (word_idx_q == cnt_q - 16'd1) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_DATA;
                    word_idx_d = word_idx_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            words_q    <= words_d;
        end
    end

    assign core_rst     = (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign err          = (state_q == S_ERROR);
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;

endmodule
